data_mem_initiator: RTL and testbench

- CPU-side master for the data memory; sequences load/store requests from the control unit onto the memory's read_write/addr/data_in_memory/data_out_memory interface.
- The memory reacts combinationally to addr/read_write changes. This block therefore:
  - registers and holds every memory-facing signal stable for a fixed settle window;
  - keeps read_write low whenever idle;
  - returns results over a valid/ready response handshake.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_settle_timer.sv | 37 +++
 rtl/data_mem_initiator.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_initiator.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and default widths for the data-memory initiator slice.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 9;
    localparam int unsigned DMEM_DATA_W = 16;
    localparam int unsigned DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ACCESS    = 2'b01,
        WRITEBACK = 2'b10,
        RESP      = 2'b11
    } state_e;

endpackage

// File: rtl/dmem_settle_timer.sv
// Loadable down-counter with a zero flag; paces each memory phase.
module dmem_settle_timer
    import dmem_pkg::*;
#(
    parameter int unsigned CNT_W = DMEM_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/data_mem_initiator.sv
// CPU-side data-memory master: holds memory signals stable for a settle window per phase.
// MEM_RMW_EN enables read-modify-write for bit-set/bit-clear; otherwise they read and flag an error.
module data_mem_initiator
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = DMEM_ADDR_W,
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CNT_W       = DMEM_CNT_W;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic req_fire_c;
    logic tmr_load_c;
    logic tmr_dec_c;
    logic tmr_zero_c;

    assign req_fire_c = req_valid && req_ready_q;

`ifdef MEM_RMW_EN
    // mem_wdata_q still carries the latched mask during the read phase
    logic [DATA_W-1:0] rmw_data_c;
    assign rmw_data_c = (op_q == OP_SET) ? (mem_rdata | mem_wdata_q)
                                         : (mem_rdata & ~mem_wdata_q);
`endif

    dmem_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load_c),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (tmr_dec_c),
        .zero_c     (tmr_zero_c)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        tmr_load_c   = 1'b0;
        tmr_dec_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_fire_c) begin
                    state_d     = ACCESS;
                    op_d        = op_e'(req_op);
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                    mem_rw_d    = (op_e'(req_op) == OP_WRITE);
                    req_ready_d = 1'b0;
                    resp_err_d  = 1'b0;
                    tmr_load_c  = 1'b1;
                end
            end

            ACCESS: begin
                if (!tmr_zero_c) begin
                    tmr_dec_c = 1'b1;
                end else begin
                    case (op_q)
                        OP_READ: begin
                            resp_rdata_d = mem_rdata;
                            resp_valid_d = 1'b1;
                            state_d      = RESP;
                        end
                        OP_WRITE: begin
                            mem_rw_d     = 1'b0;
                            resp_rdata_d = '0;
                            resp_valid_d = 1'b1;
                            state_d      = RESP;
                        end
                        default: begin
`ifdef MEM_RMW_EN
                            // old value parks in resp_rdata until the writeback finishes
                            resp_rdata_d = mem_rdata;
                            mem_wdata_d  = rmw_data_c;
                            mem_rw_d     = 1'b1;
                            tmr_load_c   = 1'b1;
                            state_d      = WRITEBACK;
`else
                            resp_rdata_d = mem_rdata;
                            resp_err_d   = 1'b1;
                            resp_valid_d = 1'b1;
                            state_d      = RESP;
`endif
                        end
                    endcase
                end
            end

`ifdef MEM_RMW_EN
            WRITEBACK: begin
                if (!tmr_zero_c) begin
                    tmr_dec_c = 1'b1;
                end else begin
                    mem_rw_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
`endif

            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d      = IDLE;
                mem_rw_d     = 1'b0;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_read_write = mem_rw_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Scoreboard bench for data_mem_initiator: random ops against an array reference model.
module tb_data_mem_initiator;
    import dmem_pkg::*;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 16;
    localparam int unsigned W     = 3;
    localparam int unsigned DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          mem_read_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    data_mem_initiator #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_CYCLES (W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_read_write (mem_read_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational-read memory that writes every cycle read_write is high
    function automatic logic [DW-1:0] init_val(int i);
        if (i == 4) return 16'h0001;
        return DW'((32'(i) * 32'd2654435761) >> 9);
    endfunction

    logic [DW-1:0] mem [DEPTH];
    logic          mem_init_done = 1'b0;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_val(i);
            mem_init_done <= 1'b1;
        end else if (mem_read_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    logic [DW-1:0] ref_mem [DEPTH];

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic [31:0]   acc;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;
    bit in_rst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_junk();
        req_op    = 2'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
    endtask

    // Issue one request once the block is ready; junk req_valid while busy must be ignored
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int   waited;
        exp_t e;
        waited = 0;
        while (!req_ready) begin
            req_valid = 1'($urandom);
            drive_junk();
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL req_ready_timeout: got 0 expected 1 within 200 cycles");
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        e.err   = 1'b0;
        e.rdata = ref_mem[addr];
        case (op)
            2'b00: ;
            2'b01: begin
                e.rdata = '0;
                ref_mem[addr] = wdata;
            end
            default: begin
`ifdef MEM_RMW_EN
                ref_mem[addr] = (op == 2'b10) ? (ref_mem[addr] | wdata) : (ref_mem[addr] & ~wdata);
`else
                e.err = 1'b1;
`endif
            end
        endcase
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        drive_junk();
    endtask

    // Monitor: response scoreboard plus memory-interface stability rules
    initial begin
        int unsigned   rw_len;
        bit            prev_rw, prev_hs, prev_stall, prev_valid;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] snap_rdata;
        logic          snap_err;
        exp_t          e;
        rw_len = 0; prev_rw = 0; prev_hs = 0; prev_stall = 0; prev_valid = 0;
        prev_addr = '0; snap_rdata = '0; snap_err = 1'b0;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || in_rst) begin
                rw_len = 0; prev_rw = 0; prev_hs = 0; prev_stall = 0; prev_valid = 0;
                resp_ready = 1'b0;
                continue;
            end
            if (mem_read_write) begin
                rw_len++;
            end else begin
                if (prev_rw) chk("write_pulse_len", 32'(rw_len), 32'(W));
                rw_len = 0;
            end
            if (prev_rw) chk("addr_stable_while_writing", 32'(mem_addr), 32'(prev_addr));
            if (prev_hs) begin
                chk("req_ready_after_handshake", 32'(req_ready), 32'd1);
                chk("resp_valid_after_handshake", 32'(resp_valid), 32'd0);
            end
            if (prev_stall) begin
                chk("stall_resp_valid", 32'(resp_valid), 32'd1);
                chk("stall_resp_rdata", 32'(resp_rdata), 32'(snap_rdata));
                chk("stall_resp_err", 32'(resp_err), 32'(snap_err));
                chk("stall_req_ready", 32'(req_ready), 32'd0);
            end
            if (resp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_response: got rdata 0x%0h expected no response", resp_rdata);
                end else begin
                    chk("resp_latency", cyc - exp_q[0].acc, 32'(W));
                end
            end
            case (ready_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = ($urandom_range(0, 1) == 1);
                default: resp_ready = ($urandom_range(0, 3) == 0);
            endcase
            prev_hs = 0;
            prev_stall = 0;
            if (resp_valid) begin
                if (resp_ready) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                        chk("resp_err", 32'(resp_err), 32'(e.err));
                    end
                    prev_hs = 1;
                end else begin
                    prev_stall = 1;
                    snap_rdata = resp_rdata;
                    snap_err   = resp_err;
                end
            end
            prev_rw    = mem_read_write;
            prev_addr  = mem_addr;
            prev_valid = resp_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_val(i);
        repeat (3) @(negedge clk);

        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);
        chk("reset_mem_read_write", 32'(mem_read_write), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;

        // Directed: resp_ready tied high
        ready_mode = 0;
        issue(2'b00, 9'd4, 16'hA5A5);
        issue(2'b01, 9'd0, 16'h0001);
        issue(2'b00, 9'd0, 16'h1234);
        issue(2'b01, 9'd0, 16'h00F0);
        issue(2'b10, 9'd0, 16'h0001);
        issue(2'b00, 9'd0, 16'h0000);
        issue(2'b11, 9'd511, 16'hFFFF);
        issue(2'b00, 9'd511, 16'h0000);

        // Heavy back-pressure
        ready_mode = 2;
        for (int k = 0; k < 20; k++)
            issue(2'($urandom), AW'($urandom), DW'($urandom));

        // Random mix with boundary addresses
        ready_mode = 1;
        for (int k = 0; k < 300; k++) begin
            logic [AW-1:0] a;
            case ($urandom_range(0, 7))
                0:       a = '0;
                1:       a = '1;
                2:       a = AW'($urandom_range(0, 7));
                default: a = AW'($urandom);
            endcase
            issue(2'($urandom), a, DW'($urandom));
        end

        waited = 0;
        while ((exp_q.size() != 0 || !req_ready) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_pending_responses", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < int'(DEPTH); i++)
            chk($sformatf("mem_contents[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));

        // Reset mid-write: one write cycle reaches memory, then nothing more
        in_rst    = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_addr  = 9'h1A5;
        req_wdata = 16'hBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_write_active", 32'(mem_read_write), 32'd1);
        ref_mem[9'h1A5] = 16'hBEEF;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_mem_read_write", 32'(mem_read_write), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("abort_resp_err", 32'(resp_err), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < int'(2 * W + 4); k++) begin
            @(negedge clk);
            chk("abort_no_second_write", 32'(mem_read_write), 32'd0);
            chk("abort_no_response", 32'(resp_valid), 32'd0);
        end
        chk("abort_mem_word", 32'(mem[9'h1A5]), 32'(ref_mem[9'h1A5]));
        in_rst = 1'b0;

        // Still functional after the abort
        ready_mode = 1;
        issue(2'b00, 9'h1A5, 16'h0000);
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("post_abort_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
